// File: rtl/simple_bus_collector_pkg.sv
// Shared types and default widths for the simple_bus lane collector.
// Compile first; the FIFO and top import it.
package simple_bus_collector_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   localparam int TS_W_DEFAULT  = 8;
   localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/simple_bus_collector_fifo.sv
// Small register-based FIFO for change records; head entry is read straight from flops.
// clear_i empties the queue synchronously and wins over push/pop.
module simple_bus_collector_fifo
   import simple_bus_collector_pkg::*;
#(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W:0]   count_q;
   logic             doPush;
   logic             doPop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign doPop   = pop_i && !empty_o;
   // A push into a full queue is only taken when the head leaves in the same cycle.
   assign doPush  = push_i && (!full_o || doPop);
   assign data_o  = mem_q[rdPtr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
            wrPtr_q        <= wrPtr_q + PTR_W'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + PTR_W'(1);
         end
         if (doPush && !doPop) begin
            count_q <= count_q + (PTR_W+1)'(1);
         end else if (doPop && !doPush) begin
            count_q <= count_q - (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/simple_bus_collector.sv
// Samples the packed simple_bus lane vector, timestamps changes and queues them for a consumer.
// Define SIMPLE_BUS_COLLECTOR_STATS_EN to build the saturating drop counter.
module simple_bus_collector
   import simple_bus_collector_pkg::*;
#(
   parameter int NUM_LANES = 10,
   parameter int DEPTH     = 4,
   parameter int TS_W      = TS_W_DEFAULT,
   parameter int CNT_W     = CNT_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [NUM_LANES-1:0] in_a,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NUM_LANES-1:0] out_lanes,
   output logic [TS_W-1:0]      out_ts,
   output logic                 overflow,
   output logic [CNT_W-1:0]     drop_cnt
);

   localparam int REC_W = NUM_LANES + TS_W;

   state_e               state_q;
   state_e               state_d;
   logic [TS_W-1:0]      ts_q;
   logic [NUM_LANES-1:0] last_q;
   logic                 overflow_q;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic [REC_W-1:0]     fifoData;
   logic                 pushReq;
   logic                 popReq;
   logic                 dropEvt;

   // The first sample after arming is always recorded, later ones only on change.
   assign pushReq = in_valid && !flush && ((state_q == IDLE) || (in_a != last_q));
   assign popReq  = !fifoEmpty && out_ready;
   assign dropEvt = pushReq && fifoFull && !popReq;

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else if (in_valid) begin
         state_d = RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ts_q       <= '0;
         last_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ts_q    <= ts_q + TS_W'(1);
         if (in_valid && !flush) begin
            last_q <= in_a;
         end
         if (dropEvt) begin
            overflow_q <= 1'b1;
         end
      end
   end

`ifdef SIMPLE_BUS_COLLECTOR_STATS_EN
   logic [CNT_W-1:0] dropCnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dropCnt_q <= '0;
      end else if (dropEvt && (dropCnt_q != '1)) begin
         dropCnt_q <= dropCnt_q + CNT_W'(1);
      end
   end

   assign drop_cnt = dropCnt_q;
`else
   assign drop_cnt = '0;
`endif

   simple_bus_collector_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (flush),
      .push_i  (pushReq),
      .data_i  ({in_a, ts_q}),
      .pop_i   (popReq),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .data_o  (fifoData)
   );

   assign out_valid              = !fifoEmpty;
   assign {out_lanes, out_ts}    = fifoData;
   assign overflow               = overflow_q;

endmodule

// File: tb/tb_simple_bus_collector.sv
// Self-checking bench for simple_bus_collector: directed table, corner sequences, random vs a queue model.
// Honours SIMPLE_BUS_COLLECTOR_STATS_EN for the expected drop_cnt.
module tb_simple_bus_collector;

   localparam int NUM_LANES = 10;
   localparam int DEPTH     = 4;
   localparam int TS_W      = 8;
   localparam int CNT_W     = 8;
`ifdef SIMPLE_BUS_COLLECTOR_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic [NUM_LANES-1:0] in_a;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [NUM_LANES-1:0] out_lanes;
   logic [TS_W-1:0]      out_ts;
   logic                 overflow;
   logic [CNT_W-1:0]     drop_cnt;

   int vecCount  = 0;
   int missCount = 0;

   simple_bus_collector #(
      .NUM_LANES (NUM_LANES),
      .DEPTH     (DEPTH),
      .TS_W      (TS_W),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_a      (in_a),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_lanes (out_lanes),
      .out_ts    (out_ts),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a queue of {lanes, ts} records plus the arm flag and last sample.
   typedef struct {
      logic [NUM_LANES-1:0] lanes;
      logic [TS_W-1:0]      ts;
   } rec_t;

   rec_t                 mQ[$];
   logic [TS_W-1:0]      mTs;
   logic                 mArmed;
   logic [NUM_LANES-1:0] mLast;
   logic                 mOvf;
   int                   mDrops;

   task automatic modelReset();
      mQ.delete();
      mTs    = '0;
      mArmed = 1'b0;
      mLast  = '0;
      mOvf   = 1'b0;
      mDrops = 0;
   endtask

   // One clock of the model, using the inputs present just before the edge.
   task automatic modelStep();
      bit popped;
      bit wantPush;
      popped = (mQ.size() > 0) && out_ready;
      if (flush) begin
         mQ.delete();
         mArmed = 1'b0;
      end else begin
         wantPush = in_valid && (!mArmed || (in_a != mLast));
         if (in_valid) begin
            mLast  = in_a;
            mArmed = 1'b1;
         end
         if (popped) void'(mQ.pop_front());
         if (wantPush) begin
            if (mQ.size() < DEPTH) begin
               mQ.push_back('{lanes: in_a, ts: mTs});
            end else begin
               mOvf = 1'b1;
               if (mDrops < (2**CNT_W - 1)) mDrops++;
            end
         end
      end
      mTs = mTs + 8'd1;
   endtask

   // Drive one cycle of inputs, clock it through DUT and model, settle before returning.
   task automatic applyStimulus(input logic v, input logic [NUM_LANES-1:0] a,
                                input logic fl, input logic rd);
      in_valid  = v;
      in_a      = a;
      flush     = fl;
      out_ready = rd;
      @(posedge clk);
      modelStep();
      #2;
   endtask

   // Compare every visible output against the model.
   task automatic checkOutput(input string name);
      logic                 expV;
      logic [NUM_LANES-1:0] expL;
      logic [TS_W-1:0]      expT;
      logic [CNT_W-1:0]     expD;
      expV = (mQ.size() > 0);
      expL = expV ? mQ[0].lanes : '0;
      expT = expV ? mQ[0].ts : '0;
      expD = STATS_EN ? CNT_W'(mDrops) : '0;
      vecCount++;
      if ((out_valid !== expV) || (expV && ((out_lanes !== expL) || (out_ts !== expT))) ||
          (overflow !== mOvf) || (drop_cnt !== expD)) begin
         missCount++;
         $display("[TB] FAIL %s: got v=%0b lanes=%h ts=%h ovf=%0b drop=%0d, want v=%0b lanes=%h ts=%h ovf=%0b drop=%0d",
                  name, out_valid, out_lanes, out_ts, overflow, drop_cnt, expV, expL, expT, mOvf, expD);
      end
   endtask

   // Single explicit comparison against a hand-derived value.
   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic                 v;
      logic [NUM_LANES-1:0] a;
      logic                 fl;
      logic                 rd;
      logic                 expV;
      logic [NUM_LANES-1:0] expL;
      logic [TS_W-1:0]      expT;
   } vec_t;

   vec_t tbl[8];

   // Main sequence: reset, directed table, corner sequences, random phase, mid-run reset.
   initial begin
      logic [NUM_LANES-1:0] drainExp[4];
      int                   seen;
      logic [NUM_LANES-1:0] ra;

      tbl[0] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00};
      tbl[1] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00};
      tbl[2] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00};
      tbl[3] = '{1'b1, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000, 8'h03};
      tbl[4] = '{1'b1, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 8'h00};
      tbl[5] = '{1'b1, 10'h200, 1'b0, 1'b0, 1'b1, 10'h200, 8'h05};
      tbl[6] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h200, 8'h05};
      tbl[7] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 8'h00};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checkValue("reset_valid", 32'(out_valid), 32'd0);
      checkValue("reset_lanes", 32'(out_lanes), 32'd0);
      checkValue("reset_ts", 32'(out_ts), 32'd0);
      checkValue("reset_ovf", 32'(overflow), 32'd0);
      checkValue("reset_drop", 32'(drop_cnt), 32'd0);
      rst_n = 1'b1;
      modelReset();

      for (int i = 0; i < 8; i++) begin
         applyStimulus(tbl[i].v, tbl[i].a, tbl[i].fl, tbl[i].rd);
         checkValue($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].expV));
         if (tbl[i].expV) begin
            checkValue($sformatf("tbl%0d_lanes", i), 32'(out_lanes), 32'(tbl[i].expL));
            checkValue($sformatf("tbl%0d_ts", i), 32'(out_ts), 32'(tbl[i].expT));
         end
      end

      seen = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 10'h000, 1'b0, 1'b1);
         checkOutput("hold_same");
         if (out_valid) seen++;
      end
      checkValue("hold_one_record", 32'(seen), 32'd1);
      checkValue("hold_empty", 32'(out_valid), 32'd0);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? 10'h200 : 10'h000, 1'b0, 1'b0);
         checkOutput("toggle_fill");
      end
      checkValue("fill_ovf", 32'(overflow), 32'd1);
      checkValue("fill_drop", 32'(drop_cnt), STATS_EN ? 32'd2 : 32'd0);
      checkValue("fill_head", 32'(out_lanes), 32'h200);

      applyStimulus(1'b1, 10'h001, 1'b0, 1'b1);
      checkOutput("full_push_pop");
      checkValue("full_ovf_kept", 32'(overflow), 32'd1);
      checkValue("full_drop_kept", 32'(drop_cnt), STATS_EN ? 32'd2 : 32'd0);

      drainExp[0] = 10'h000;
      drainExp[1] = 10'h200;
      drainExp[2] = 10'h000;
      drainExp[3] = 10'h001;
      for (int i = 0; i < 4; i++) begin
         checkValue($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
         checkValue($sformatf("drain%0d_lanes", i), 32'(out_lanes), 32'(drainExp[i]));
         applyStimulus(1'b0, 10'h001, 1'b0, 1'b1);
      end
      checkValue("drain_empty", 32'(out_valid), 32'd0);

      for (int i = 0; i < 300 && mTs != 8'hFF; i++) begin
         applyStimulus(1'b0, 10'h001, 1'b0, 1'b0);
      end
      checkValue("wrap_reached", 32'(mTs), 32'hFF);
      applyStimulus(1'b1, 10'h155, 1'b0, 1'b0);
      applyStimulus(1'b1, 10'h0AA, 1'b0, 1'b0);
      checkOutput("wrap_pair");
      checkValue("wrap_ts_ff", 32'(out_ts), 32'hFF);
      applyStimulus(1'b0, 10'h0AA, 1'b0, 1'b1);
      checkValue("wrap_ts_00", 32'(out_ts), 32'h00);
      checkValue("wrap_lanes", 32'(out_lanes), 32'h0AA);
      applyStimulus(1'b0, 10'h0AA, 1'b0, 1'b1);
      checkOutput("wrap_drained");

      applyStimulus(1'b1, 10'h001, 1'b0, 1'b0);
      applyStimulus(1'b1, 10'h002, 1'b0, 1'b0);
      applyStimulus(1'b1, 10'h003, 1'b0, 1'b0);
      checkOutput("flush_prefill");
      applyStimulus(1'b1, 10'h3FF, 1'b1, 1'b1);
      checkValue("flush_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 10'h003, 1'b0, 1'b0);
      checkValue("rearm_valid", 32'(out_valid), 32'd1);
      checkValue("rearm_lanes", 32'(out_lanes), 32'h003);
      checkOutput("rearm_model");

      for (int i = 0; i < 400; i++) begin
         ra = NUM_LANES'($urandom) & 10'h207;
         applyStimulus(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 29) == 0),
                       1'($urandom_range(0, 1)));
         checkOutput("random");
      end

      #1;
      rst_n = 1'b0;
      #1;
      checkValue("async_reset_valid", 32'(out_valid), 32'd0);
      checkValue("async_reset_ovf", 32'(overflow), 32'd0);
      checkValue("async_reset_drop", 32'(drop_cnt), 32'd0);
      modelReset();
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 60; i++) begin
         ra = NUM_LANES'($urandom) & 10'h003;
         applyStimulus(1'($urandom_range(0, 1)), ra, 1'b0, ($urandom_range(0, 3) == 0));
         checkOutput("post_reset_random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
